// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift/rotate unit. Moves a WIDTH-bit operand by at
// most STEP positions per clock, with valid/ready handshakes on both sides.
module iter_shifter #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         shift_mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    M_SRL = 3'b000,
    M_SLL = 3'b001,
    M_SRA = 3'b010,
    M_ROR = 3'b011,
    M_ROL = 3'b100
  } mode_t;

  // One extra bit so STEP == WIDTH and WIDTH itself are representable.
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W + 1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W + 1)'(WIDTH);

  state_t             state, state_nx;
  mode_t              mode_q;
  logic               sign_q;
  logic               err_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [WIDTH-1:0]   work_q;

  logic               accept;
  logic               legal;
  logic               last_step;
  logic [SHAMT_W:0]   step_amt;
  logic [SHAMT_W:0]   wrap_amt;
  logic [WIDTH:0]     sra_ext;
  logic [WIDTH-1:0]   stepped;

  assign legal  = (shift_mode <= 3'b100);
  assign accept = in_valid && in_ready;

  // One partial shift of the working register by min(rem, STEP).
  always_comb begin
    // NOTE: every signal gets a value before the case so no latch is inferred.
    stepped   = work_q;
    step_amt  = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
    wrap_amt  = WIDTH_C - step_amt;
    last_step = ({1'b0, rem_q} <= STEP_C);
    // The captured sign is prepended so every step fills with it, not with
    // whatever the working register's MSB happens to be.
    sra_ext   = $signed({sign_q, work_q}) >>> step_amt;
    case (mode_q)
      M_SRL:   stepped = work_q >> step_amt;
      M_SLL:   stepped = work_q << step_amt;
      M_SRA:   stepped = sra_ext[WIDTH-1:0];
      M_ROR:   stepped = (work_q >> step_amt) | (work_q << wrap_amt);
      M_ROL:   stepped = (work_q << step_amt) | (work_q >> wrap_amt);
      default: stepped = work_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_nx = (!legal || shamt == '0) ? DONE : RUN;
      end
      RUN:  if (last_step) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iterative shifting and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      err_q  <= 1'b0;
      rem_q  <= '0;
      sign_q <= 1'b0;
      mode_q <= M_SRL;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values, independent of statement order.
      case (state)
        IDLE: if (accept) begin
          rem_q  <= shamt;
          sign_q <= data_in[WIDTH-1];
          mode_q <= legal ? mode_t'(shift_mode) : M_SRL;
          work_q <= legal ? data_in : '0;
          err_q  <= !legal;
        end
        RUN: begin
          work_q <= stepped;
          rem_q  <= rem_q - step_amt[SHAMT_W-1:0];
        end
        DONE: if (out_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign data_out = work_q;
  assign err      = err_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed vector table plus randomized regression of
// iter_shifter against a single-shot shift/rotate reference model, for
// STEP = 1, 4 and 32 at WIDTH = 32.
module tb_iter_shifter;

  localparam int W     = 32;
  localparam int N     = 3;
  localparam int STEPS [N] = '{1, 4, 32};
  localparam int NRAND = 1500;
  localparam int D4    = 1;  // index of the STEP = 4 instance

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]        in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [N-1:0][2:0]   shift_mode;
  logic [N-1:0][4:0]   shamt;
  logic [N-1:0][W-1:0] data_in, data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    iter_shifter #(.WIDTH(W), .STEP(STEPS[g])) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .shift_mode (shift_mode[g]),
      .shamt      (shamt[g]),
      .data_in    (data_in[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .data_out   (data_out[g]),
      .err        (err[g]),
      .busy       (busy[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the whole shift in one go, straight from the mode definitions.
  function automatic logic [W-1:0] ref_shift(input logic [2:0] m, input logic [4:0] sh,
                                             input logic [W-1:0] d, output logic e);
    logic [2*W-1:0] dd;
    dd = {d, d};
    e  = 1'b0;
    case (m)
      3'd0: return d >> sh;
      3'd1: return d << sh;
      3'd2: return W'($signed(d) >>> sh);
      3'd3: begin dd = dd >> sh; return dd[W-1:0]; end
      3'd4: begin dd = dd << sh; return dd[2*W-1:W]; end
      default: begin e = 1'b1; return '0; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] m, input logic [4:0] sh, input int step);
    if (m > 3'd4 || sh == 0) return 0;
    return (int'(sh) + step - 1) / step;
  endfunction

  // Issues one request on instance i (entered and left at a negedge), waits for
  // the result, holds out_ready low for 'stall' cycles, then drains it.
  task automatic run_op(input int i, input logic [2:0] m, input logic [4:0] sh,
                        input logic [W-1:0] d, input int stall,
                        output logic [W-1:0] res, output logic e, output int lat);
    int guard = 0;
    in_valid[i] = 1'b1; shift_mode[i] = m; shamt[i] = sh; data_in[i] = d;
    while (!in_ready[i] && guard < 200) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    check("accept_wait", in_ready[i], 1);
    @(posedge clk);                       // E0
    @(negedge clk);
    // Scramble the operand inputs: they must not influence the running op.
    in_valid[i] = 1'b0; data_in[i] = $urandom; shamt[i] = 5'($urandom);
    shift_mode[i] = 3'($urandom);
    lat = 0;
    while (!out_valid[i] && lat < 100) begin
      check("run_busy", busy[i], 1);
      @(posedge clk); lat++; @(negedge clk);
    end
    check("done_wait", out_valid[i], 1);
    check("done_busy", busy[i], 1);
    check("done_in_ready", in_ready[i], 0);
    res = data_out[i];
    e   = err[i];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", out_valid[i], 1);
      check("hold_data", data_out[i], res);
      check("hold_err", err[i], e);
    end
    out_ready[i] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready[i] = 1'b0;
    check("exit_in_ready", in_ready[i], 1);
    check("exit_out_valid", out_valid[i], 0);
    check("exit_err", err[i], 0);
    check("exit_data_kept", data_out[i], res);
  endtask

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic [4:0] sh;
    logic [W-1:0] d;
    logic [W-1:0] exp_d;
    logic       exp_e;
    int         exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [W-1:0] res, exp_d;
    logic e, exp_e, ov_seen;
    int lat;
    logic [2:0] m;
    logic [4:0] sh;
    logic [W-1:0] d;

    in_valid = '0; out_ready = '0; shift_mode = '0; shamt = '0; data_in = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data", data_out[D4], 0);
    check("rst_err", err[D4], 0);
    check("rst_out_valid", out_valid[D4], 0);
    check("rst_busy", busy[D4], 0);
    check("rst_in_ready", in_ready[D4], 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on STEP = 4.
    vecs.push_back('{"srl31",    3'd0, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 8});
    vecs.push_back('{"sra31",    3'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 8});
    vecs.push_back('{"sra4",     3'd2, 5'd4,  32'h7000_0000, 32'h0700_0000, 1'b0, 1});
    vecs.push_back('{"sll0",     3'd1, 5'd0,  32'h0000_0001, 32'h0000_0001, 1'b0, 0});
    vecs.push_back('{"sll5",     3'd1, 5'd5,  32'h0000_0001, 32'h0000_0020, 1'b0, 2});
    vecs.push_back('{"ror1",     3'd3, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{"rol4",     3'd4, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0, 1});
    vecs.push_back('{"rol16",    3'd4, 5'd16, 32'h1234_5678, 32'h5678_1234, 1'b0, 4});
    vecs.push_back('{"ror31",    3'd3, 5'd31, 32'h1234_5678, 32'h2468_ACF0, 1'b0, 8});
    vecs.push_back('{"sra0",     3'd2, 5'd0,  32'h8000_0000, 32'h8000_0000, 1'b0, 0});
    vecs.push_back('{"ill7",     3'd7, 5'd9,  32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"ill5",     3'd5, 5'd0,  32'h1234_5678, 32'h0000_0000, 1'b1, 0});
    foreach (vecs[k]) begin
      run_op(D4, vecs[k].mode, vecs[k].sh, vecs[k].d, 0, res, e, lat);
      check({vecs[k].name, "_data"}, res, vecs[k].exp_d);
      check({vecs[k].name, "_err"}, e, vecs[k].exp_e);
      check({vecs[k].name, "_lat"}, lat, vecs[k].exp_lat);
    end

    // Backpressure, ignored in_valid during DONE, and the one-cycle bubble.
    in_valid[D4] = 1'b1; shift_mode[D4] = 3'd0; shamt[D4] = 5'd4; data_in[D4] = 32'hF0;
    @(posedge clk); @(negedge clk);
    in_valid[D4] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp_valid", out_valid[D4], 1);
    check("bp_data", data_out[D4], 32'h0F);
    for (int c = 0; c < 3; c++) begin
      in_valid[D4] = (c == 1); shift_mode[D4] = 3'd1; shamt[D4] = 5'd3; data_in[D4] = 32'h1;
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", out_valid[D4], 1);
      check("bp_hold_in_ready", in_ready[D4], 0);
      check("bp_hold_data", data_out[D4], 32'h0F);
    end
    out_ready[D4] = 1'b1;
    in_valid[D4] = 1'b1; shift_mode[D4] = 3'd1; shamt[D4] = 5'd1; data_in[D4] = 32'h1;
    @(posedge clk); @(negedge clk);
    out_ready[D4] = 1'b0;
    check("bubble_in_ready", in_ready[D4], 1);
    check("bubble_out_valid", out_valid[D4], 0);
    check("bubble_data", data_out[D4], 32'h0F);
    @(posedge clk); @(negedge clk);
    in_valid[D4] = 1'b0;
    check("bubble_accepted", in_ready[D4], 0);
    @(posedge clk); @(negedge clk);
    check("bubble_req_valid", out_valid[D4], 1);
    check("bubble_req_data", data_out[D4], 32'h2);
    out_ready[D4] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready[D4] = 1'b0;

    // Reset during RUN discards the request.
    in_valid[D4] = 1'b1; shift_mode[D4] = 3'd0; shamt[D4] = 5'd31; data_in[D4] = 32'h8000_0000;
    @(posedge clk); @(negedge clk);
    in_valid[D4] = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_data", data_out[D4], 0);
    check("abort_in_ready", in_ready[D4], 1);
    check("abort_busy", busy[D4], 0);
    check("abort_out_valid", out_valid[D4], 0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      ov_seen |= out_valid[D4];
    end
    check("abort_no_result", ov_seen, 0);
    run_op(D4, 3'd1, 5'd1, 32'h1, 0, res, e, lat);
    check("after_abort_data", res, 32'h2);
    check("after_abort_lat", lat, 1);

    // Random regression against the reference model.
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < NRAND; t++) begin
        m  = 3'($urandom_range(0, 4));
        sh = 5'($urandom);
        d  = $urandom;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        run_op(i, m, sh, d, $urandom_range(0, 2), res, e, lat);
        exp_d = ref_shift(m, sh, d, exp_e);
        check($sformatf("rand_s%0d_data", STEPS[i]), res, exp_d);
        check($sformatf("rand_s%0d_err", STEPS[i]), e, exp_e);
        check($sformatf("rand_s%0d_lat", STEPS[i]), lat, ref_lat(m, sh, STEPS[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
